lbm_sweep_sequencer: RTL

Parametrised grid-sweep sequencer for the D2Q9 lattice-Boltzmann datapath. It walks every cell of an NX x NY grid once per time step for a programmable number of steps. For each cell it presents the cell address, the wall flags and the nine streaming destination addresses with a validity mask, under a valid/ready handshake. It also toggles a ping-pong bank select between steps. It generalises the fixed 16x16 controller sweep to arbitrary grid dimensions, run-time step count, backpressure and abort.

---
 rtl/lbm_sweep_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lbm_sweep_sequencer.sv
// D2Q9 lattice-Boltzmann grid-sweep sequencer: walks NX x NY cells per time step, emitting streaming targets.
// Optional macro PERIODIC_X_EN makes the x direction periodic instead of bounce-back walls.
module lbm_sweep_sequencer #(
    parameter int NX               = 16,
    parameter int NY               = 16,
    parameter int MAX_TIME         = 8,
    parameter int ADDRESS_WIDTH    = $clog2(NX*NY),
    parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [TIME_COUNT_WIDTH:0]     num_steps,
    input  logic                          cell_ready,
    output logic                          cell_valid,
    output logic [ADDRESS_WIDTH-1:0]      cell_addr,
    output logic                          LID,
    output logic                          BOTTOM_WALL,
    output logic                          LEFT_WALL,
    output logic                          RIGHT_WALL,
    output logic [9*ADDRESS_WIDTH-1:0]    stream_addr,
    output logic [8:0]                    stream_mask,
    output logic [TIME_COUNT_WIDTH:0]     time_count,
    output logic                          bank_sel,
    output logic                          busy,
    output logic                          step_done,
    output logic                          done,
    output logic [1:0]                    state_dbg
);

    // Handshake: a cell transfers on any rising edge where cell_valid && cell_ready;
    // while cell_valid is high and cell_ready low, every cell output holds its value.

    localparam int AW = ADDRESS_WIDTH;
    localparam int TW = TIME_COUNT_WIDTH + 1;

    localparam logic [AW-1:0]        X_LAST = AW'(NX - 1);
    localparam logic [AW-1:0]        Y_LAST = AW'(NY - 1);
    localparam logic [AW-1:0]        NX_A   = AW'(NX);
    localparam logic signed [AW:0]   NX_S   = (AW+1)'(NX);
    localparam logic signed [AW:0]   NY_S   = (AW+1)'(NY);
    localparam logic signed [AW:0]   ZERO_S = '0;
    localparam logic [TW-1:0]        MAX_T  = TW'(MAX_TIME);
    localparam logic [TW-1:0]        ONE_T  = TW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SWEEP    = 2'd1,
        STEP_END = 2'd2,
        FINISH   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   x_q, y_q, x_d, y_d;
    logic [TW-1:0]   steps_q, steps_d, time_d, steps_clamped;
    logic            bank_d;
    logic            xfer;

    logic [AW-1:0]   addr_d;
    logic            lid_d, bottom_d, left_d, right_d;
    logic [9*AW-1:0] stream_d;
    logic [8:0]      mask_d;
    logic signed [1:0]  dx, dy;
    logic signed [AW:0] sx, sy;

    assign xfer          = cell_valid && cell_ready;
    assign steps_clamped = (num_steps > MAX_T) ? MAX_T : num_steps;
    assign state_dbg     = state_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        time_d  = time_count;
        steps_d = steps_q;
        bank_d  = bank_sel;
        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            time_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        steps_d = steps_clamped;
                        x_d     = '0;
                        y_d     = '0;
                        time_d  = '0;
                        state_d = (steps_clamped == '0) ? FINISH : SWEEP;
                    end
                end
                SWEEP: begin
                    if (xfer) begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) begin
                                y_d     = '0;
                                state_d = STEP_END;
                                bank_d  = ~bank_sel;
                            end else begin
                                y_d = y_q + 1'b1;
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
                STEP_END: begin
                    if (time_count + ONE_T == steps_q) begin
                        state_d = FINISH;
                    end else begin
                        state_d = SWEEP;
                        time_d  = time_count + ONE_T;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Cell geometry is computed from the next coordinates so the outputs leave the flops aligned with state.
    always_comb begin
        addr_d   = '0;
        lid_d    = 1'b0;
        bottom_d = 1'b0;
        left_d   = 1'b0;
        right_d  = 1'b0;
        stream_d = '0;
        mask_d   = '0;
        dx       = '0;
        dy       = '0;
        sx       = '0;
        sy       = '0;
        if (state_d == SWEEP) begin
            addr_d   = y_d * NX_A + x_d;
            lid_d    = (y_d == Y_LAST);
            bottom_d = (y_d == '0);
`ifdef PERIODIC_X_EN
            left_d   = 1'b0;
            right_d  = 1'b0;
`else
            left_d   = (x_d == '0);
            right_d  = (x_d == X_LAST);
`endif
            for (int i = 0; i < 9; i++) begin
                case (i)
                    1:       begin dx = 2'sb01; dy = 2'sb00; end
                    2:       begin dx = 2'sb00; dy = 2'sb01; end
                    3:       begin dx = 2'sb11; dy = 2'sb00; end
                    4:       begin dx = 2'sb00; dy = 2'sb11; end
                    5:       begin dx = 2'sb01; dy = 2'sb01; end
                    6:       begin dx = 2'sb11; dy = 2'sb01; end
                    7:       begin dx = 2'sb11; dy = 2'sb11; end
                    8:       begin dx = 2'sb01; dy = 2'sb11; end
                    default: begin dx = 2'sb00; dy = 2'sb00; end
                endcase
                // Signed, one bit wider than an address, so x-1 at the edge is -1 rather than a wrapped value.
                sx = $signed({1'b0, x_d}) + $signed({{(AW-1){dx[1]}}, dx});
                sy = $signed({1'b0, y_d}) + $signed({{(AW-1){dy[1]}}, dy});
`ifdef PERIODIC_X_EN
                if (sx < ZERO_S) begin
                    sx = NX_S - 1'sb1;
                end else if (sx == NX_S) begin
                    sx = ZERO_S;
                end
`endif
                if ((sx >= ZERO_S) && (sx < NX_S) && (sy >= ZERO_S) && (sy < NY_S)) begin
                    mask_d[i]            = 1'b1;
                    stream_d[i*AW +: AW] = AW'(sy) * NX_A + AW'(sx);
                end else begin
                    mask_d[i]            = 1'b0;
                    stream_d[i*AW +: AW] = addr_d;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            steps_q     <= '0;
            time_count  <= '0;
            bank_sel    <= 1'b0;
            cell_valid  <= 1'b0;
            cell_addr   <= '0;
            LID         <= 1'b0;
            BOTTOM_WALL <= 1'b0;
            LEFT_WALL   <= 1'b0;
            RIGHT_WALL  <= 1'b0;
            stream_addr <= '0;
            stream_mask <= '0;
            busy        <= 1'b0;
            step_done   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            steps_q     <= steps_d;
            time_count  <= time_d;
            bank_sel    <= bank_d;
            cell_valid  <= (state_d == SWEEP);
            cell_addr   <= addr_d;
            LID         <= lid_d;
            BOTTOM_WALL <= bottom_d;
            LEFT_WALL   <= left_d;
            RIGHT_WALL  <= right_d;
            stream_addr <= stream_d;
            stream_mask <= mask_d;
            busy        <= (state_d != IDLE);
            step_done   <= (state_d == STEP_END);
            done        <= (state_d == FINISH);
        end
    end

endmodule
